slc3_mem_arbiter: RTL and testbench

Two-port SRAM access sequencer and arbiter for the SLC-3 top level. It shares the single off-chip SRAM between the CPU datapath (MAR/MDR memory cycle) and the switch-driven debug/loader port. It grants one requester at a time using two-way round-robin and drives the SRAM strobes through a fixed wait-state sequence. It returns a one-cycle acknowledge with read data.

---
 rtl/slc3_mem_pkg.sv | 29 ++
 rtl/slc3_mem_arbiter_rr_arb2.sv | 45 ++++
 rtl/slc3_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and widths for the SLC-3 SRAM arbiter.
package slc3_mem_pkg;

    localparam int SRAM_AW = 20;
    localparam int WORD_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } port_e;

    // Map a one-hot grant vector onto the port index it selects.
    function automatic port_e gnt_to_port(input logic [1:0] gnt);
        port_e p;
        if (gnt[1]) begin
            p = LDR;
        end else begin
            p = CPU;
        end
        return p;
    endfunction

endpackage

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; remembers the last granted port.
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    port_e last_grant_q;
    port_e last_grant_d;

    // One-hot grant: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == LDR) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Record the winner whenever the sequencer accepts a grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (update && (gnt != 2'b00)) begin
            last_grant_d = gnt_to_port(gnt);
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register; reset to LDR so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// SRAM access sequencer shared by the CPU and loader ports.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [WORD_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [WORD_W-1:0]  cpu_rdata,
    input  logic               ldr_req,
    input  logic               ldr_we,
    input  logic [WORD_W-1:0]  ldr_addr,
    input  logic [WORD_W-1:0]  ldr_wdata,
    output logic               ldr_ack,
    output logic [WORD_W-1:0]  ldr_rdata,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [WORD_W-1:0]  sram_wdata,
    output logic               sram_wdata_oe,
    input  logic [WORD_W-1:0]  sram_rdata
);

    localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES - 1);

    state_e              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    port_e               gnt_port_q, gnt_port_d;
    logic                we_q, we_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic [WORD_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic [WORD_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [WORD_W-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ldr_ack_q, ldr_ack_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                wdata_oe_q, wdata_oe_d;

    logic [1:0]          req_vec_s;
    logic [1:0]          gnt_s;
    logic                arb_update_s;

    assign req_vec_s    = {ldr_req, cpu_req};
    assign arb_update_s = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .req    (req_vec_s),
        .update (arb_update_s),
        .gnt    (gnt_s)
    );

    // Next-state logic: grant capture in IDLE, wait countdown and read latch in ACCESS.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        gnt_port_d   = gnt_port_q;
        we_d         = we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_vec_s != 2'b00) begin
                    state_d    = ACCESS;
                    wcnt_d     = WCNT_INIT;
                    gnt_port_d = gnt_to_port(gnt_s);
                    if (gnt_s[1]) begin
                        we_d         = ldr_we;
                        sram_addr_d  = {4'b0000, ldr_addr};
                        sram_wdata_d = ldr_wdata;
                    end else begin
                        we_d         = cpu_we;
                        sram_addr_d  = {4'b0000, cpu_addr};
                        sram_wdata_d = cpu_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q && (gnt_port_q == LDR)) begin
                        ldr_rdata_d = sram_rdata;
                    end else if (!we_q) begin
                        cpu_rdata_d = sram_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every pin comes straight off a flop.
    always_comb begin
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        wdata_oe_d = 1'b0;
        cpu_ack_d  = 1'b0;
        ldr_ack_d  = 1'b0;
        case (state_d)
            ACCESS: begin
                ce_n_d     = 1'b0;
                oe_n_d     = we_d;
                we_n_d     = ~we_d;
                wdata_oe_d = we_d;
            end
            DONE: begin
                // Keep the pad driven one more cycle on writes for data hold.
                wdata_oe_d = we_d;
                cpu_ack_d  = (gnt_port_d == CPU);
                ldr_ack_d  = (gnt_port_d == LDR);
            end
            default: begin
                ce_n_d     = 1'b1;
                wdata_oe_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            wcnt_q       <= 4'd0;
            gnt_port_q   <= CPU;
            we_q         <= 1'b0;
            sram_addr_q  <= 20'h00000;
            sram_wdata_q <= 16'h0000;
            cpu_rdata_q  <= 16'h0000;
            ldr_rdata_q  <= 16'h0000;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            wdata_oe_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            gnt_port_q   <= gnt_port_d;
            we_q         <= we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            wdata_oe_q   <= wdata_oe_d;
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign ldr_ack       = ldr_ack_q;
    assign ldr_rdata     = ldr_rdata_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;
    assign sram_wdata_oe = wdata_oe_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter.
module tb_slc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [15:0] ldr_addr = 16'h0000, ldr_wdata = 16'h0000;
    logic        cpu_ack, ldr_ack;
    logic [15:0] cpu_rdata, ldr_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata, model_rd;

    logic        sw_req = 1'b0;
    logic        ws1_cpu_ack, ws1_ldr_ack, ws1_ce_n, ws1_oe_n, ws1_we_n, ws1_woe;
    logic [15:0] ws1_cpu_rdata, ws1_ldr_rdata, ws1_wdata;
    logic [19:0] ws1_addr;
    logic        ws15_cpu_ack, ws15_ldr_ack, ws15_ce_n, ws15_oe_n, ws15_we_n, ws15_woe;
    logic [15:0] ws15_cpu_rdata, ws15_ldr_rdata, ws15_wdata;
    logic [19:0] ws15_addr;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    slc3_mem_arbiter #(.WAIT_STATES(2)) u_dut (
        .Clk(clk), .Reset_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata)
    );

    slc3_mem_arbiter #(.WAIT_STATES(1)) u_ws1 (
        .Clk(clk), .Reset_n(rst_n),
        .cpu_req(sw_req), .cpu_we(1'b0), .cpu_addr(16'h0007), .cpu_wdata(16'h0000),
        .cpu_ack(ws1_cpu_ack), .cpu_rdata(ws1_cpu_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(16'h0000),
        .ldr_ack(ws1_ldr_ack), .ldr_rdata(ws1_ldr_rdata),
        .sram_ce_n(ws1_ce_n), .sram_oe_n(ws1_oe_n), .sram_we_n(ws1_we_n),
        .sram_addr(ws1_addr), .sram_wdata(ws1_wdata), .sram_wdata_oe(ws1_woe),
        .sram_rdata(16'hC3C3)
    );

    slc3_mem_arbiter #(.WAIT_STATES(15)) u_ws15 (
        .Clk(clk), .Reset_n(rst_n),
        .cpu_req(sw_req), .cpu_we(1'b0), .cpu_addr(16'h0007), .cpu_wdata(16'h0000),
        .cpu_ack(ws15_cpu_ack), .cpu_rdata(ws15_cpu_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(16'h0000),
        .ldr_ack(ws15_ldr_ack), .ldr_rdata(ws15_ldr_rdata),
        .sram_ce_n(ws15_ce_n), .sram_oe_n(ws15_oe_n), .sram_we_n(ws15_we_n),
        .sram_addr(ws15_addr), .sram_wdata(ws15_wdata), .sram_wdata_oe(ws15_woe),
        .sram_rdata(16'hC3C3)
    );

    // SRAM model: fixed seed contents, overlaid by words written since reset.
    logic [15:0] mem [0:63];
    logic [63:0] written;

    function automatic logic [15:0] seed(input logic [5:0] a);
        logic [15:0] v;
        case (a)
            6'h31:   v = 16'h1234;
            6'h10:   v = 16'hAAAA;
            6'h20:   v = 16'h5555;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Write port of the SRAM model.
    always @(posedge clk) begin
        if (!rst_n) begin
            written <= 64'd0;
        end else if (!sram_ce_n && !sram_we_n && sram_wdata_oe) begin
            mem[sram_addr[5:0]]     <= sram_wdata;
            written[sram_addr[5:0]] <= 1'b1;
        end
    end

    // Asynchronous read port of the SRAM model.
    always_comb begin
        model_rd = seed(sram_addr[5:0]);
        if (written[sram_addr[5:0]]) begin
            model_rd = mem[sram_addr[5:0]];
        end
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? model_rd : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until either ack, tallying strobe activity on the main DUT.
    task automatic watch(input int max_cyc, output int lat, output int oe_low,
                         output int we_low, output int woe_high, output logic [19:0] addr_seen);
        logic got_ack;
        lat = 0; oe_low = 0; we_low = 0; woe_high = 0; addr_seen = 20'h0;
        got_ack = 1'b0;
        while (!got_ack && lat < max_cyc) begin
            step();
            lat++;
            if (!sram_ce_n) addr_seen = sram_addr;
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (sram_wdata_oe) woe_high++;
            if (cpu_ack || ldr_ack) got_ack = 1'b1;
        end
        chk("ack_seen", {31'd0, got_ack}, 32'd1);
    endtask

    initial begin
        int lat, oe_low, we_low, woe_high, acks;
        logic [19:0] a_seen;
        int ord [4];
        int cyc [4];
        int n_ack;
        int lat1, lat15;

        // Reset values
        rst_n = 1'b0;
        step(); step();
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_woe", {31'd0, sram_wdata_oe}, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 32'd0);
        chk("rst_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_wdata", {16'd0, sram_wdata}, 32'd0);

        // Reset in the middle of a read aborts it
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0031;
        step();
        chk("mid_access_ce", {31'd0, sram_ce_n}, 32'd0);
        rst_n = 1'b0; cpu_req = 1'b0;
        step();
        chk("mid_rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("mid_rst_ack", {31'd0, cpu_ack}, 32'd0);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_ack || ldr_ack) acks++;
        end
        chk("mid_rst_no_ack", acks, 32'd0);

        // CPU read of 0x0031
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0031;
        watch(10, lat, oe_low, we_low, woe_high, a_seen);
        cpu_req = 1'b0;
        chk("rd_latency", lat, 32'd3);
        chk("rd_addr", {12'd0, a_seen}, 32'h00031);
        chk("rd_oe_low", oe_low, 32'd2);
        chk("rd_we_low", we_low, 32'd0);
        chk("rd_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("rd_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        chk("rd_cpu_rdata", {16'd0, cpu_rdata}, 32'h1234);
        chk("rd_ldr_rdata", {16'd0, ldr_rdata}, 32'h0000);
        step();
        chk("rd_ack_pulse", {31'd0, cpu_ack}, 32'd0);
        chk("rd_rdata_hold", {16'd0, cpu_rdata}, 32'h1234);

        // Loader write of 0xBEEF to 0x0005
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0005; ldr_wdata = 16'hBEEF;
        watch(10, lat, oe_low, we_low, woe_high, a_seen);
        ldr_req = 1'b0;
        chk("wr_latency", lat, 32'd3);
        chk("wr_addr", {12'd0, a_seen}, 32'h00005);
        chk("wr_we_low", we_low, 32'd2);
        chk("wr_oe_low", oe_low, 32'd0);
        chk("wr_woe_high", woe_high, 32'd3);
        chk("wr_ldr_ack", {31'd0, ldr_ack}, 32'd1);
        chk("wr_wdata", {16'd0, sram_wdata}, 32'hBEEF);
        chk("wr_mem", {16'd0, mem[5]}, 32'hBEEF);
        chk("wr_cpu_rdata", {16'd0, cpu_rdata}, 32'h1234);
        step();
        chk("wr_woe_off", {31'd0, sram_wdata_oe}, 32'd0);

        // Early drop: request falls right after grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        cpu_req = 1'b0;
        watch(10, lat, oe_low, we_low, woe_high, a_seen);
        chk("drop_latency", lat, 32'd2);
        chk("drop_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("drop_rdata", {16'd0, cpu_rdata}, 32'hAAAA);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_ack || ldr_ack) acks++;
        end
        chk("drop_single_ack", acks, 32'd0);

        // Simultaneous requests out of reset alternate CPU, LDR, CPU, LDR
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0020;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            ord[i] = 9; cyc[i] = 0;
        end
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            step();
            if (cpu_ack || ldr_ack) begin
                ord[n_ack] = (cpu_ack && ldr_ack) ? 2 : (ldr_ack ? 1 : 0);
                cyc[n_ack] = c;
                n_ack++;
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk("tie_ack_count", n_ack, 32'd4);
        chk("tie_order0", ord[0], 32'd0);
        chk("tie_order1", ord[1], 32'd1);
        chk("tie_order2", ord[2], 32'd0);
        chk("tie_order3", ord[3], 32'd1);
        chk("tie_first_lat", cyc[0], 32'd3);
        chk("tie_gap1", cyc[1] - cyc[0], 32'd4);
        chk("tie_gap2", cyc[2] - cyc[1], 32'd4);
        chk("tie_gap3", cyc[3] - cyc[2], 32'd4);
        chk("tie_cpu_rdata", {16'd0, cpu_rdata}, 32'hAAAA);
        chk("tie_ldr_rdata", {16'd0, ldr_rdata}, 32'h5555);
        step(); step();

        // Wait-state sweep: WAIT_STATES = 1 and 15
        lat1 = 0; lat15 = 0;
        sw_req = 1'b1;
        for (int c = 1; c <= 40 && (lat1 == 0 || lat15 == 0); c++) begin
            step();
            if (c == 1) sw_req = 1'b0;
            if (ws1_cpu_ack && lat1 == 0) lat1 = c;
            if (ws15_cpu_ack && lat15 == 0) lat15 = c;
        end
        chk("ws1_latency", lat1, 32'd2);
        chk("ws15_latency", lat15, 32'd16);
        chk("ws1_rdata", {16'd0, ws1_cpu_rdata}, 32'hC3C3);
        chk("ws15_rdata", {16'd0, ws15_cpu_rdata}, 32'hC3C3);
        chk("ws15_ldr_side", {14'd0, ws15_ldr_ack, ws1_ldr_ack, ws15_ldr_rdata}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
